// File: rtl/cdc_req_ctrl.sv
// 4-phase request/acknowledge controller toward a remote clock domain.
// Payload is registered on acceptance; the remote ack is synchronized before use.
module cdc_req_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  req_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ack_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  timeout_o
);

  localparam int               CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_i};
    end
  end

  assign ack_s   = ack_sync[SYNC_STAGES-1];
  assign ready_o = (state == IDLE) && !ack_s;
  assign busy_o  = (state != IDLE);

  // The counter only runs while waiting for ack; it stops at the limit so the
  // transfer can still complete late, with timeout_o left set as a warning.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      req_o     <= 1'b0;
      data_o    <= '0;
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      cnt       <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && ready_o) begin
            data_o    <= data_i;
            req_o     <= 1'b1;
            cnt       <= '0;
            timeout_o <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if ((TIMEOUT_CYCLES > 0) && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
            if ((cnt + CNT_ONE) == CNT_MAX) begin
              timeout_o <= 1'b1;
            end
          end
          if (ack_s) begin
            req_o <= 1'b0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
        end
        default: begin
          req_o <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_ctrl.sv
// Directed bench for cdc_req_ctrl (SYNC_STAGES=2, TIMEOUT_CYCLES=8) with a
// behavioural remote that can hold ack, echo req, or echo it after random delays.
module tb_cdc_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] data_i = '0;
  logic        req_o;
  logic [31:0] data_o;
  logic        ack_i = 1'b0;
  logic        busy_o;
  logic        done_o;
  logic        timeout_o;

  int checks = 0;
  int fails  = 0;

  // remote behaviour: 0 = ack forced to forced_ack, 1 = echo req, 2 = echo after random delay
  int   mode = 0;
  logic forced_ack = 1'b0;
  int   delay_left = 0;

  cdc_req_ctrl #(
    .SYNC_STAGES   (2),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data_i   (data_i),
    .req_o    (req_o),
    .data_o   (data_o),
    .ack_i    (ack_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    case (mode)
      0: ack_i = forced_ack;
      1: ack_i = req_o;
      default: begin
        if (ack_i !== req_o) begin
          if (delay_left == 0) begin
            ack_i      = req_o;
            delay_left = int'($urandom_range(20, 0));
          end else begin
            delay_left--;
          end
        end
      end
    endcase
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    mode = 0; forced_ack = 1'b0; valid_i = 1'b0; data_i = '0;
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    checks++; if (req_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_req: got %b want 0", req_o); end
    checks++; if (data_o !== 32'h0) begin fails++; $display("[TB] FAIL reset_data: got %h want 0", data_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b want 0", done_o); end
    checks++; if (timeout_o !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b want 0", timeout_o); end
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    #1;
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready_first: got %b want 1", ready_o); end
    tick();
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL reset_ready: got %b want 1", ready_o); end
  endtask

  task automatic test_basic();
    logic exp_req, exp_done;
    mode = 1;
    valid_i = 1'b1; data_i = 32'hA5A5_0001;
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready_pre: got %b want 1", ready_o); end
    tick();
    valid_i = 1'b0; data_i = 32'h0;
    checks++; if (req_o !== 1'b1) begin fails++; $display("[TB] FAIL basic_req_rise: got %b want 1", req_o); end
    checks++; if (data_o !== 32'hA5A5_0001) begin fails++; $display("[TB] FAIL basic_data: got %h want a5a50001", data_o); end
    checks++; if (ready_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_ready_busy: got %b want 0", ready_o); end
    checks++; if (busy_o !== 1'b1) begin fails++; $display("[TB] FAIL basic_busy: got %b want 1", busy_o); end
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp_req  = (k < 3);
      exp_done = (k == 6);
      checks++; if (req_o !== exp_req) begin fails++; $display("[TB] FAIL basic_req_c%0d: got %b want %b", k, req_o, exp_req); end
      checks++; if (done_o !== exp_done) begin fails++; $display("[TB] FAIL basic_done_c%0d: got %b want %b", k, done_o, exp_done); end
      checks++; if (data_o !== 32'hA5A5_0001) begin fails++; $display("[TB] FAIL basic_hold_c%0d: got %h want a5a50001", k, data_o); end
    end
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL basic_ready_post: got %b want 1", ready_o); end
    checks++; if (busy_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_busy_post: got %b want 0", busy_o); end
    tick();
    checks++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done_o); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [3];
    int   acc, rises, dones;
    logic prev_req, take;
    words[0] = 32'h1111_0000; words[1] = 32'h2222_0001; words[2] = 32'h3333_0002;
    acc = 0; rises = 0; dones = 0;
    mode = 1;
    valid_i = 1'b1; data_i = words[0];
    prev_req = req_o;
    for (int cyc = 1; cyc <= 40 && dones < 3; cyc++) begin
      take = valid_i && ready_o;
      tick();
      if (take) begin
        acc++;
        if (acc < 3) data_i = words[acc];
        else begin valid_i = 1'b0; data_i = '0; end
      end
      checks++; if (busy_o && ready_o) begin fails++; $display("[TB] FAIL b2b_overlap_c%0d: got busy=%b ready=%b want not both", cyc, busy_o, ready_o); end
      if (req_o && !prev_req) begin
        checks++;
        if (rises >= 3) begin fails++; $display("[TB] FAIL b2b_extra_req: got pulse %0d want 3 max", rises + 1); end
        else if (data_o !== words[rises]) begin fails++; $display("[TB] FAIL b2b_data%0d: got %h want %h", rises, data_o, words[rises]); end
        rises++;
      end
      if (done_o) begin
        checks++; if (cyc != 7 * (dones + 1)) begin fails++; $display("[TB] FAIL b2b_done_time%0d: got cycle %0d want %0d", dones, cyc, 7 * (dones + 1)); end
        dones++;
      end
      prev_req = req_o;
    end
    valid_i = 1'b0;
    checks++; if (rises != 3) begin fails++; $display("[TB] FAIL b2b_req_count: got %0d want 3", rises); end
    checks++; if (dones != 3) begin fails++; $display("[TB] FAIL b2b_done_count: got %0d want 3", dones); end
    checks++; if (acc != 3) begin fails++; $display("[TB] FAIL b2b_accept_count: got %0d want 3", acc); end
  endtask

  task automatic test_timeout();
    logic exp_to;
    mode = 0; forced_ack = 1'b0;
    tick();
    checks++; if (timeout_o !== 1'b0) begin fails++; $display("[TB] FAIL to_clear_pre: got %b want 0", timeout_o); end
    valid_i = 1'b1; data_i = 32'hC0DE_0007;
    tick();
    valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_to = (k >= 8);
      checks++; if (timeout_o !== exp_to) begin fails++; $display("[TB] FAIL to_flag_c%0d: got %b want %b", k, timeout_o, exp_to); end
      checks++; if (req_o !== 1'b1) begin fails++; $display("[TB] FAIL to_req_c%0d: got %b want 1", k, req_o); end
    end
    forced_ack = 1'b1;
    repeat (2) tick();
    checks++; if (req_o !== 1'b1) begin fails++; $display("[TB] FAIL to_req_hold: got %b want 1", req_o); end
    tick();
    checks++; if (req_o !== 1'b0) begin fails++; $display("[TB] FAIL to_req_fall: got %b want 0", req_o); end
    forced_ack = 1'b0;
    repeat (2) tick();
    checks++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL to_done_early: got %b want 0", done_o); end
    tick();
    checks++; if (done_o !== 1'b1) begin fails++; $display("[TB] FAIL to_done: got %b want 1", done_o); end
    checks++; if (timeout_o !== 1'b1) begin fails++; $display("[TB] FAIL to_sticky: got %b want 1", timeout_o); end
    mode = 1;
    valid_i = 1'b1; data_i = 32'h5A5A_0002;
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL to_ready_next: got %b want 1", ready_o); end
    tick();
    valid_i = 1'b0;
    checks++; if (timeout_o !== 1'b0) begin fails++; $display("[TB] FAIL to_clear_accept: got %b want 0", timeout_o); end
    checks++; if (data_o !== 32'h5A5A_0002) begin fails++; $display("[TB] FAIL to_next_data: got %h want 5a5a0002", data_o); end
    for (int n = 0; n < 30 && !done_o; n++) tick();
    checks++; if (done_o !== 1'b1) begin fails++; $display("[TB] FAIL to_next_done: got %b want 1 within budget", done_o); end
  endtask

  task automatic test_stale_ack();
    mode = 0; forced_ack = 1'b1; valid_i = 1'b0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;
    repeat (2) tick();
    checks++; if (ready_o !== 1'b0) begin fails++; $display("[TB] FAIL stale_ready: got %b want 0", ready_o); end
    valid_i = 1'b1; data_i = 32'hDEAD_0003;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (busy_o !== 1'b0 || req_o !== 1'b0) begin fails++; $display("[TB] FAIL stale_ignored_c%0d: got busy=%b req=%b want 0/0", k, busy_o, req_o); end
    end
    forced_ack = 1'b0;
    tick();
    checks++; if (ready_o !== 1'b0) begin fails++; $display("[TB] FAIL stale_ready_lag: got %b want 0", ready_o); end
    tick();
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL stale_ready_back: got %b want 1", ready_o); end
    tick();
    valid_i = 1'b0;
    checks++; if (req_o !== 1'b1 || data_o !== 32'hDEAD_0003) begin fails++; $display("[TB] FAIL stale_accept: got req=%b data=%h want 1/dead0003", req_o, data_o); end
    mode = 1;
    for (int n = 0; n < 30 && !done_o; n++) tick();
    checks++; if (done_o !== 1'b1) begin fails++; $display("[TB] FAIL stale_done: got %b want 1 within budget", done_o); end
  endtask

  task automatic test_reset_mid();
    mode = 1;
    valid_i = 1'b1; data_i = 32'h0BAD_0004;
    tick();
    valid_i = 1'b0;
    checks++; if (req_o !== 1'b1) begin fails++; $display("[TB] FAIL rmid_req_up: got %b want 1", req_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (req_o !== 1'b0 || busy_o !== 1'b0 || data_o !== 32'h0) begin fails++; $display("[TB] FAIL rmid_req_async: got req=%b busy=%b data=%h want 0/0/0", req_o, busy_o, data_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    valid_i = 1'b1; data_i = 32'h0BAD_0005;
    tick();
    valid_i = 1'b0;
    repeat (3) tick();
    checks++; if (busy_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("[TB] FAIL rmid_release: got busy=%b req=%b want 1/0", busy_o, req_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0 || req_o !== 1'b0 || done_o !== 1'b0) begin fails++; $display("[TB] FAIL rmid_rel_async: got busy=%b req=%b done=%b want 0/0/0", busy_o, req_o, done_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    #1 rst_ni = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL rmid_no_done_c%0d: got %b want 0", k, done_o); end
    end
    valid_i = 1'b1; data_i = 32'h600D_0006;
    checks++; if (ready_o !== 1'b1) begin fails++; $display("[TB] FAIL rmid_ready_after: got %b want 1", ready_o); end
    tick();
    valid_i = 1'b0;
    checks++; if (data_o !== 32'h600D_0006 || req_o !== 1'b1) begin fails++; $display("[TB] FAIL rmid_next_accept: got req=%b data=%h want 1/600d0006", req_o, data_o); end
    for (int n = 0; n < 30 && !done_o; n++) tick();
    checks++; if (done_o !== 1'b1) begin fails++; $display("[TB] FAIL rmid_next_done: got %b want 1 within budget", done_o); end
  endtask

  task automatic test_random();
    logic [31:0] word;
    logic        prev_req, bad_data;
    int          toggles, bad_count;
    bad_count = 0;
    mode = 2; delay_left = 0;
    tick();
    for (int n = 0; n < 1000; n++) begin
      word = $urandom;
      repeat ($urandom_range(2, 0)) tick();
      valid_i = 1'b1; data_i = word;
      for (int w = 0; w < 100 && !ready_o; w++) tick();
      if (ready_o !== 1'b1) begin
        checks++; fails++;
        $display("[TB] FAIL rand_ready%0d: got %b want 1 within budget", n, ready_o);
        valid_i = 1'b0;
        break;
      end
      tick();
      valid_i = 1'b0; data_i = $urandom;
      prev_req = req_o; toggles = 0; bad_data = 1'b0;
      if (data_o !== word || req_o !== 1'b1) bad_data = 1'b1;
      for (int w = 0; w < 200 && !done_o; w++) begin
        tick();
        if (req_o !== prev_req) toggles++;
        prev_req = req_o;
        if (data_o !== word) bad_data = 1'b1;
      end
      checks++; if (done_o !== 1'b1) begin fails++; $display("[TB] FAIL rand_done%0d: got %b want 1 within budget", n, done_o); break; end
      checks++; if (toggles != 1) begin fails++; $display("[TB] FAIL rand_req_toggles%0d: got %0d want 1", n, toggles); end
      if (bad_data) bad_count++;
      tick();
      checks++; if (done_o !== 1'b0) begin fails++; $display("[TB] FAIL rand_done_pulse%0d: got %b want 0", n, done_o); end
    end
    checks++; if (bad_count != 0) begin fails++; $display("[TB] FAIL rand_data_order: got %0d bad transfers want 0", bad_count); end
    mode = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_stale_ack();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
